// File: rtl/cache_i_param_pkg.sv
// Shared types and constants for the parametrised instruction cache.
// Contains the controller state encoding and the bus widths used by the
// cache and its line assembler.
package cache_i_param_pkg;

  // Controller states:
  //   ICACHE_IDLE : lookups served combinationally; a miss launches a refill
  //   ICACHE_FILL : line being fetched byte by byte from the memory controller
  typedef enum logic {
    ICACHE_IDLE = 1'b0,
    ICACHE_FILL = 1'b1
  } icache_state_e;

  localparam int REG_BITS  = 32;
  localparam int BYTE_BITS = 8;

  // Byte-offset width inside a line of line_words 32-bit words.
  function automatic int off_bits(input int line_words);
    return $clog2(line_words) + 2;
  endfunction

endpackage

// File: rtl/cache_i_param_line_assembler.sv
// Byte-serial line assembler. It holds the refill byte counter and the
// staging buffer. line_o already includes the byte arriving this cycle, so
// the cache can write the whole line on the last beat without waiting.
module icache_line_assembler
  import cache_i_param_pkg::*;
#(
  parameter int LINE_BYTES = 8
) (
  input  logic                            clk,
  input  logic                            clear,
  input  logic                            beat,
  input  logic [BYTE_BITS-1:0]            data_i,
  output logic [$clog2(LINE_BYTES)-1:0]   cnt_o,
  output logic [LINE_BYTES*BYTE_BITS-1:0] line_o,
  output logic                            last_o
);

  localparam int CNT_BITS = $clog2(LINE_BYTES);

  logic [CNT_BITS-1:0]  cnt_q;
  logic [BYTE_BITS-1:0] buf_q [LINE_BYTES];

  // Byte counter: restarts on any clear; wraps to 0 after the last beat.
  always_ff @(posedge clk) begin
    if (clear) cnt_q <= '0;
    else if (beat) cnt_q <= cnt_q + 1'b1;
  end

  // Staging buffer: the accepted byte lands at the current count.
  always_ff @(posedge clk) begin
    if (beat) buf_q[cnt_q] <= data_i;
  end

  // Assembled line with the in-flight byte merged in.
  always_comb begin
    line_o = '0;
    for (int i = 0; i < LINE_BYTES; i++) begin
      if (beat && (cnt_q == CNT_BITS'(i))) line_o[i*BYTE_BITS +: BYTE_BITS] = data_i;
      else line_o[i*BYTE_BITS +: BYTE_BITS] = buf_q[i];
    end
  end

  assign cnt_o  = cnt_q;
  assign last_o = beat && (cnt_q == CNT_BITS'(LINE_BYTES - 1));

endmodule

// File: rtl/cache_i_param.sv
// Direct-mapped instruction cache between the fetch stage and a byte-wide
// memory controller. Hits return in the request cycle; misses refill a whole
// line from a latched base address. Build with ICACHE_STATS_EN defined to get
// hit/miss counters on hit_cnt_o / miss_cnt_o.
module cache_i_param
  import cache_i_param_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int INDEX_BITS = 7,
  parameter int LINE_WORDS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  branch_error,
  input  logic                  flush_i,
  input  logic                  request_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic [REG_BITS-1:0]   data_o,
  output logic                  done_o,
  output logic                  request_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  input  logic [BYTE_BITS-1:0]  data_i,
  input  logic                  done_i
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]           hit_cnt_o,
  output logic [31:0]           miss_cnt_o
`endif
);

  localparam int OFF_BITS   = off_bits(LINE_WORDS);
  localparam int TAG_BITS   = ADDR_WIDTH - INDEX_BITS - OFF_BITS;
  localparam int LINE_BYTES = 4 * LINE_WORDS;
  localparam int LINES      = 1 << INDEX_BITS;
  localparam int CNT_BITS   = $clog2(LINE_BYTES);
  localparam int WSEL_BITS  = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

  icache_state_e state_q, state_d;

  logic [LINES-1:0]            valid_q;
  logic [TAG_BITS-1:0]         tag_mem  [LINES];
  logic [LINE_BYTES*8-1:0]     data_mem [LINES];
  logic [ADDR_WIDTH-1:0]       fill_addr_q;

  logic [INDEX_BITS-1:0]       idx, fill_idx;
  logic [TAG_BITS-1:0]         req_tag, fill_tag;
  logic [WSEL_BITS-1:0]        word_sel;
  logic                        hit, abort, beat, start_fill, line_last;
  logic [CNT_BITS-1:0]         cnt;
  logic [LINE_BYTES*8-1:0]     line;
  logic [REG_BITS-1:0]         hit_word;
  logic                        unused_addr_bits;

  assign idx      = addr_i[OFF_BITS +: INDEX_BITS];
  assign req_tag  = addr_i[ADDR_WIDTH-1 -: TAG_BITS];
  assign fill_idx = fill_addr_q[OFF_BITS +: INDEX_BITS];
  assign fill_tag = fill_addr_q[ADDR_WIDTH-1 -: TAG_BITS];
  assign unused_addr_bits = ^addr_i[1:0];

  if (LINE_WORDS > 1) begin : g_wsel
    assign word_sel = addr_i[OFF_BITS-1:2];
  end else begin : g_wsel_one
    assign word_sel = '0;
  end

  assign hit      = valid_q[idx] && (tag_mem[idx] == req_tag);
  assign hit_word = data_mem[idx][word_sel*REG_BITS +: REG_BITS];

  // Redirect and fence.i both kill a refill; they win over the last beat.
  assign abort = branch_error | flush_i;
  assign beat  = (state_q == ICACHE_FILL) && done_i && !abort && !rst;

  icache_line_assembler #(
    .LINE_BYTES(LINE_BYTES)
  ) u_asm (
    .clk    (clk),
    .clear  (rst | abort),
    .beat   (beat),
    .data_i (data_i),
    .cnt_o  (cnt),
    .line_o (line),
    .last_o (line_last)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ICACHE_IDLE;
    else state_q <= state_d;
  end

  // Next state and outputs; everything is held low while in reset.
  always_comb begin
    state_d    = state_q;
    done_o     = 1'b0;
    data_o     = '0;
    request_o  = 1'b0;
    addr_o     = '0;
    start_fill = 1'b0;
    if (!rst) begin
      case (state_q)
        ICACHE_IDLE: begin
          if (request_i) begin
            if (hit) begin
              done_o = 1'b1;
              data_o = hit_word;
            end else begin
              start_fill = 1'b1;
              state_d    = ICACHE_FILL;
            end
          end
        end
        ICACHE_FILL: begin
          if (!abort) begin
            request_o = 1'b1;
            addr_o    = fill_addr_q + ADDR_WIDTH'(cnt);
          end
          if (abort || line_last) state_d = ICACHE_IDLE;
        end
        default: state_d = ICACHE_IDLE;
      endcase
    end
  end

  // Latch the line base on a miss so later addr_i changes cannot disturb it.
  always_ff @(posedge clk) begin
    if (rst) fill_addr_q <= '0;
    else if (start_fill) fill_addr_q <= {addr_i[ADDR_WIDTH-1:OFF_BITS], {OFF_BITS{1'b0}}};
  end

  // Valid bits: cleared by reset or flush, set when a line completes.
  always_ff @(posedge clk) begin
    if (rst || flush_i) valid_q <= '0;
    else if (line_last) valid_q[fill_idx] <= 1'b1;
  end

  // Tag and data arrays are only meaningful under their valid bit.
  always_ff @(posedge clk) begin
    if (line_last) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= line;
    end
  end

`ifdef ICACHE_STATS_EN
  // Hit/miss statistics; flush leaves them alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else begin
      if ((state_q == ICACHE_IDLE) && request_i && hit) hit_cnt_o <= hit_cnt_o + 1'b1;
      if (start_fill) miss_cnt_o <= miss_cnt_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_i_param.sv
// Directed bench for cache_i_param with default parameters (128 lines,
// 2 words per line). Memory bytes come from a small fixed table/function.
module tb_cache_i_param;

  logic        clk;
  logic        rst;
  logic        branch_error;
  logic        flush_i;
  logic        request_i;
  logic [31:0] addr_i;
  logic [31:0] data_o;
  logic        done_o;
  logic        request_o;
  logic [31:0] addr_o;
  logic [7:0]  data_i;
  logic        done_i;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_o;
  logic [31:0] miss_cnt_o;
`endif

  int n_cmp = 0;
  int n_err = 0;

  cache_i_param dut (
    .clk          (clk),
    .rst          (rst),
    .branch_error (branch_error),
    .flush_i      (flush_i),
    .request_i    (request_i),
    .addr_i       (addr_i),
    .data_o       (data_o),
    .done_o       (done_o),
    .request_o    (request_o),
    .addr_o       (addr_o),
    .data_i       (data_i),
    .done_i       (done_i)
`ifdef ICACHE_STATS_EN
    ,
    .hit_cnt_o    (hit_cnt_o),
    .miss_cnt_o   (miss_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'h100: return 8'h13;
      32'h101: return 8'h05;
      32'h102: return 8'h10;
      32'h103: return 8'h00;
      32'h104: return 8'h93;
      32'h105: return 8'h05;
      32'h106: return 8'h20;
      32'h107: return 8'h00;
      default: return a[7:0] ^ a[15:8];
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start_miss(input logic [31:0] a);
    request_i = 1'b1;
    addr_i    = a;
    #1;
    check("miss_done", {31'd0, done_o}, 32'd0);
    tick();
  endtask

  task automatic probe_miss(input logic [31:0] a);
    request_i = 1'b1;
    addr_i    = a;
    #1;
    check("probe_miss", {31'd0, done_o}, 32'd0);
    request_i = 1'b0;
  endtask

  task automatic beats(input logic [31:0] base, input int from, input int to);
    for (int k = from; k < to; k++) begin
      #1;
      check("fill_req", {31'd0, request_o}, 32'd1);
      check("fill_addr", addr_o, base + k);
      check("fill_done", {31'd0, done_o}, 32'd0);
      done_i = 1'b1;
      data_i = mem_byte(base + k);
      tick();
      done_i = 1'b0;
    end
  endtask

  task automatic check_hit(input logic [31:0] a, input logic [31:0] exp);
    request_i = 1'b1;
    addr_i    = a;
    #1;
    check("hit_done", {31'd0, done_o}, 32'd1);
    check("hit_data", data_o, exp);
    check("hit_noreq", {31'd0, request_o}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; branch_error = 1'b0; flush_i = 1'b0; request_i = 1'b1;
    addr_i = 32'h100; data_i = 8'h00; done_i = 1'b0;
    tick();
    check("rst_done", {31'd0, done_o}, 32'd0);
    check("rst_req", {31'd0, request_o}, 32'd0);
    check("rst_data", data_o, 32'd0);
    check("rst_addr", addr_o, 32'd0);
    tick();
    rst = 1'b0;
    request_i = 1'b0;
    tick();

    // Cold miss; addr_i wanders mid-fill and must be ignored.
    start_miss(32'h100);
    beats(32'h100, 0, 3);
    addr_i = 32'h300;
    beats(32'h100, 3, 8);
    check_hit(32'h100, 32'h0010_0513);
    check_hit(32'h104, 32'h0020_0593);
    branch_error = 1'b1;
    check_hit(32'h104, 32'h0020_0593);
    branch_error = 1'b0;
    tick();

    // Conflict eviction on index 0x20.
    start_miss(32'h500);
    beats(32'h500, 0, 8);
    check_hit(32'h500, 32'h0607_0405);
    check_hit(32'h504, 32'h0203_0001);
    start_miss(32'h100);
    beats(32'h100, 0, 8);
    check_hit(32'h100, 32'h0010_0513);

    // Branch abort after 3 bytes, then restart from the line base.
    start_miss(32'h200);
    beats(32'h200, 0, 3);
    branch_error = 1'b1;
    #1;
    check("abort_req", {31'd0, request_o}, 32'd0);
    tick();
    branch_error = 1'b0;
    start_miss(32'h200);
    beats(32'h200, 0, 8);
    check_hit(32'h200, 32'h0100_0302);

    // Abort coinciding with the last byte: nothing written.
    start_miss(32'h308);
    beats(32'h308, 0, 7);
    done_i = 1'b1;
    data_i = mem_byte(32'h30f);
    branch_error = 1'b1;
    #1;
    check("abort_last_req", {31'd0, request_o}, 32'd0);
    tick();
    done_i = 1'b0;
    branch_error = 1'b0;
    start_miss(32'h308);
    beats(32'h308, 0, 8);
    check_hit(32'h308, 32'h0809_0A0B);
    check_hit(32'h30C, 32'h0C0D_0E0F);

    // Flush: the flush cycle still hits, afterwards everything misses.
    flush_i = 1'b1;
    check_hit(32'h100, 32'h0010_0513);
    tick();
    flush_i = 1'b0;
    probe_miss(32'h100);
    probe_miss(32'h200);
    probe_miss(32'h308);
    tick();

    // Flush during a fill aborts it.
    start_miss(32'h100);
    beats(32'h100, 0, 4);
    flush_i = 1'b1;
    #1;
    check("flush_fill_req", {31'd0, request_o}, 32'd0);
    tick();
    flush_i = 1'b0;
    probe_miss(32'h100);

    // done_i while idle is ignored.
    done_i = 1'b1;
    data_i = 8'hFF;
    #1;
    check("idle_done_req", {31'd0, request_o}, 32'd0);
    tick();
    done_i = 1'b0;
    #1;
    check("idle_done_req2", {31'd0, request_o}, 32'd0);

    // Reset in the middle of a fill.
    start_miss(32'h100);
    beats(32'h100, 0, 8);
    check_hit(32'h100, 32'h0010_0513);
    request_i = 1'b0;
    #1;
    check("noreq_done", {31'd0, done_o}, 32'd0);
    check("noreq_data", data_o, 32'd0);
    start_miss(32'h200);
    beats(32'h200, 0, 3);
    rst = 1'b1;
    addr_i = 32'h100;
    #1;
    check("rst_fill_req", {31'd0, request_o}, 32'd0);
    check("rst_fill_done", {31'd0, done_o}, 32'd0);
    check("rst_fill_addr", addr_o, 32'd0);
    check("rst_fill_data", data_o, 32'd0);
    tick();
    rst = 1'b0;
    request_i = 1'b0;
    #1;
    check("post_rst_req", {31'd0, request_o}, 32'd0);
`ifdef ICACHE_STATS_EN
    check("post_rst_hits", hit_cnt_o, 32'd0);
    check("post_rst_misses", miss_cnt_o, 32'd0);
`endif
    probe_miss(32'h100);
    probe_miss(32'h200);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
